// File: rtl/spi_slave_fsm.sv
// SPI slave command/data sequencer: serial command word, then one memory read or write.
// Latency: mem_addr valid the clk after the last command bit; read data on MISO after one load clk; write strobe the clk after the last data bit.
// Backpressure: none; the SPI master paces every bit, and chip-select deassertion aborts the transfer at any point.
//
// Ports:
//   clk, reset_n          system clock, synchronous active-low reset
//   cs_cond               conditioned chip select (active low)
//   sclk_pos, sclk_neg    one-clk pulses on conditioned SCLK rising / falling edges
//   mosi_cond             conditioned MOSI level
//   miso, miso_oe         serial read data and its tri-state enable
//   mem_addr              address latched from the command word
//   mem_wdata, mem_we     write data and one-clk write strobe
//   mem_rdata             combinational read data for mem_addr
module spi_slave_fsm #(
   parameter int ADDR_W = 7,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              cs_cond,
   input  logic              sclk_pos,
   input  logic              sclk_neg,
   input  logic              mosi_cond,
   output logic              miso,
   output logic              miso_oe,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int MAX_BITS = ((ADDR_W + 1) > DATA_W) ? (ADDR_W + 1) : DATA_W;
   localparam int CNT_W    = $clog2(MAX_BITS + 1);

   // Counter value seen on the clk that carries the final bit of each phase
   localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(ADDR_W);
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   typedef enum logic [2:0] {
      IDLE,
      GET_CMD,
      READ_LOAD,
      READ_SHIFT,
      WRITE_SHIFT,
      WRITE_COMMIT,
      DONE
   } state_t;

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   // Only the address bits need storage: the R/W bit is the last one in and
   // is acted on directly from mosi_cond on the completing clk.
   logic [ADDR_W-1:0] cmd_sr;
   logic [DATA_W-1:0] rd_sr;
   logic [DATA_W-1:0] wr_sr;
   logic [DATA_W-1:0] wdata_q;
   logic              commit_ok;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state    <= IDLE;
         cnt      <= '0;
         cmd_sr   <= '0;
         rd_sr    <= '0;
         wr_sr    <= '0;
         mem_addr <= '0;
         wdata_q  <= '0;
      end else if (cs_cond) begin
         // Deselect wins over everything: drop partial data and go home.
         // In IDLE this simply holds; SCLK pulses are never looked at here.
         state  <= IDLE;
         cnt    <= '0;
         cmd_sr <= '0;
         rd_sr  <= '0;
         wr_sr  <= '0;
      end else begin
         case (state)
            IDLE: begin
               state <= GET_CMD;
               cnt   <= '0;
            end

            GET_CMD: begin
               if (sclk_pos) begin
                  if (cnt == CMD_LAST) begin
                     mem_addr <= cmd_sr;
                     cnt      <= '0;
                     state    <= mosi_cond ? READ_LOAD : WRITE_SHIFT;
                  end else begin
                     cmd_sr <= {cmd_sr[ADDR_W-2:0], mosi_cond};
                     cnt    <= cnt + CNT_ONE;
                  end
               end
            end

            READ_LOAD: begin
               rd_sr <= mem_rdata;
               state <= READ_SHIFT;
            end

            READ_SHIFT: begin
               // A rising edge takes precedence; a coincident falling edge
               // must not advance the data.
               if (sclk_pos) begin
                  if (cnt == DATA_LAST) begin
                     cnt   <= '0;
                     state <= DONE;
                  end else begin
                     cnt <= cnt + CNT_ONE;
                  end
               end else if (sclk_neg) begin
                  rd_sr <= {rd_sr[DATA_W-2:0], 1'b0};
               end
            end

            WRITE_SHIFT: begin
               if (sclk_pos) begin
                  wr_sr <= {wr_sr[DATA_W-2:0], mosi_cond};
                  if (cnt == DATA_LAST) begin
                     cnt   <= '0;
                     state <= WRITE_COMMIT;
                  end else begin
                     cnt <= cnt + CNT_ONE;
                  end
               end
            end

            WRITE_COMMIT: begin
               wdata_q <= wr_sr;
               state   <= DONE;
            end

            DONE: begin
               state <= DONE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // The write is only real if neither deselect nor reset lands on the
   // commit clk; otherwise the bus keeps showing the last committed word.
   assign commit_ok = (state == WRITE_COMMIT) && !cs_cond && reset_n;
   assign mem_we    = commit_ok;
   assign mem_wdata = commit_ok ? wr_sr : wdata_q;

   // Decoded straight from the state flop, so these only move on clk edges.
   assign miso_oe = (state == READ_SHIFT);
   assign miso    = miso_oe & rd_sr[DATA_W-1];

endmodule
